// File: rtl/cacheline_adapter.sv
`default_nettype none
// cacheline_adapter: bridges a 256-bit cache line port to a 4-beat, 64-bit memory burst port.
// One transaction in flight. Read beats are assembled into line_rdata, which is valid on line_resp.
module cacheline_adapter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [LINE_W-1:0] line_rdata,
  output logic              line_resp,
  output logic [ADDR_W-1:0] burst_addr,
  output logic              burst_read,
  output logic              burst_write,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);

  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFFS_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wbuf;
  logic                accept_rd;
  logic                accept_wr;
  logic                beat_done;

  // Offset bits within a line never reach the memory side.
  logic unused_offset_bits;
  assign unused_offset_bits = ^line_addr[OFFS_W-1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    beat_done = 1'b0;
    case (state)
      IDLE: begin
        // A read wins over a simultaneous write; the write is dropped.
        if (line_read) begin
          accept_rd = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RD;
        end else if (line_write) begin
          accept_wr = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WR;
        end
      end
      RD, WR: begin
        if (burst_resp) begin
          beat_done = 1'b1;
          if (cnt == LAST_BEAT) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wbuf       <= '0;
      line_rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept_rd || accept_wr) begin
        addr_q <= {line_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
      end
      if (accept_wr) begin
        wbuf <= line_wdata;
      end
      if (state == RD && beat_done) begin
        line_rdata[cnt*BEAT_W +: BEAT_W] <= burst_rdata;
      end
    end
  end

  always_comb begin
    line_resp   = 1'b0;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    burst_addr  = '0;
    burst_wdata = '0;
    case (state)
      RD: begin
        burst_read = 1'b1;
        burst_addr = addr_q;
      end
      WR: begin
        burst_write = 1'b1;
        burst_addr  = addr_q;
        burst_wdata = wbuf[cnt*BEAT_W +: BEAT_W];
      end
      DONE: begin
        line_resp = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && state == IDLE) begin
      assert (!(line_read && line_write))
        else $warning("cacheline_adapter: read and write requested together, write dropped");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// tb_cacheline_adapter: directed plus randomized transactions against a line/burst reference model.
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  line_addr;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_addr;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int           vectors;
  int           miscompares;
  logic [255:0] last_read;
  logic [63:0]  wseq[$];

  cacheline_adapter #(.ADDR_W(32), .LINE_W(256), .BEAT_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_addr  (line_addr),
    .line_read  (line_read),
    .line_write (line_write),
    .line_wdata (line_wdata),
    .line_rdata (line_rdata),
    .line_resp  (line_resp),
    .burst_addr (burst_addr),
    .burst_read (burst_read),
    .burst_write(burst_write),
    .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata),
    .burst_resp (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One cache-side transaction, starting at a negedge with the DUT idle and ending
  // at the negedge of the idle cycle that follows line_resp.
  task automatic txn(input string name, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [255:0] wdata, input bit fixed, input logic [255:0] beats,
                     input int stall_beat, input int stall_len, input bit rand_stall);
    logic [255:0] got;
    logic [63:0]  d;
    int           beat;
    int           stalls;
    int           pend;
    int           cyc;
    bit           done;
    got    = '0;
    beat   = 0;
    stalls = 0;
    pend   = 0;
    cyc    = 0;
    done   = 1'b0;
    wseq.delete();
    line_read  = rd;
    line_write = wr;
    line_addr  = addr;
    line_wdata = wdata;
    @(posedge clk);
    #1;
    line_addr  = $urandom;
    line_wdata = rand256();
    while (!done) begin
      @(negedge clk);
      cyc++;
      burst_resp = 1'b0;
      if (line_resp) begin
        check({name, " latency"}, 256'(cyc), 256'(5 + stalls));
        check({name, " beats"}, 256'(beat), 256'(4));
        if (rd) last_read = got;
        check({name, " line_rdata"}, line_rdata, last_read);
        check({name, " done_no_burst"}, {burst_read, burst_write}, 2'b00);
        done = 1'b1;
      end else if (cyc > 60) begin
        check({name, " resp_timeout"}, line_resp, 1'b1);
        done = 1'b1;
      end else begin
        check({name, " burst_read"}, burst_read, rd);
        check({name, " burst_write"}, burst_write, wr && !rd);
        check({name, " burst_addr"}, burst_addr, {addr[31:5], 5'b0});
        if (!rd) begin
          wseq.push_back(burst_wdata);
          check({name, " burst_wdata"}, burst_wdata, wdata[(beat & 3)*64 +: 64]);
        end
        if (beat == stall_beat && pend < stall_len) begin
          pend++;
          stalls++;
        end else if (rand_stall && $urandom_range(0, 2) == 0) begin
          stalls++;
        end else if (beat < 4) begin
          d = fixed ? beats[beat*64 +: 64] : {$urandom, $urandom};
          if (rd) got[beat*64 +: 64] = d;
          burst_rdata = d;
          burst_resp  = 1'b1;
          beat++;
        end else begin
          stalls++;
        end
      end
    end
    // Cache drops the request on the line_resp cycle; memory chatter here must be ignored.
    line_read   = 1'b0;
    line_write  = 1'b0;
    burst_resp  = 1'($urandom_range(0, 1));
    burst_rdata = {$urandom, $urandom};
    @(negedge clk);
    check({name, " resp_single"}, line_resp, 1'b0);
    check({name, " idle_no_burst"}, {burst_read, burst_write}, 2'b00);
    check({name, " rdata_hold"}, line_rdata, last_read);
    burst_resp  = 1'($urandom_range(0, 1));
    burst_rdata = {$urandom, $urandom};
  endtask

  task automatic check_all_zero(input string name);
    check({name, " line_rdata"}, line_rdata, '0);
    check({name, " outs"}, {line_resp, burst_read, burst_write, burst_addr, burst_wdata}, '0);
  endtask

  initial begin
    logic [255:0] wd;
    logic [63:0]  d0;
    logic [63:0]  d1;
    logic [63:0]  exp_seq[6];
    vectors     = 0;
    miscompares = 0;
    last_read   = '0;
    rst         = 1'b0;
    line_addr   = '0;
    line_read   = 1'b0;
    line_write  = 1'b0;
    line_wdata  = '0;
    burst_rdata = '0;
    burst_resp  = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      line_addr   = $urandom;
      line_read   = 1'($urandom_range(0, 1));
      line_write  = 1'($urandom_range(0, 1));
      line_wdata  = rand256();
      burst_rdata = {$urandom, $urandom};
      burst_resp  = 1'($urandom_range(0, 1));
      #1 check_all_zero("reset");
    end
    @(negedge clk);
    line_read  = 1'b0;
    line_write = 1'b0;
    burst_resp = 1'b0;
    rst        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_idle", {line_resp, burst_read, burst_write}, 3'b000);
    end

    // Directed read with fixed beats on consecutive cycles.
    txn("rd_fixed", 1'b1, 1'b0, 32'h1234_5678, '0, 1'b1,
        {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, -1, 0, 1'b0);

    // Directed write with a two-cycle stall before the second beat.
    wd = {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
          64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000};
    txn("wr_stall", 1'b0, 1'b1, 32'h0000_0040, wd, 1'b0, '0, 1, 2, 1'b0);
    exp_seq = '{wd[63:0], wd[127:64], wd[127:64], wd[127:64], wd[191:128], wd[255:192]};
    check("wr_seq_len", 256'(wseq.size()), 256'(6));
    for (int i = 0; i < 6 && i < wseq.size(); i++) check("wr_seq", wseq[i], exp_seq[i]);

    // Read and write together: only the read burst happens.
    txn("rd_wr_both", 1'b1, 1'b1, $urandom, rand256(), 1'b0, '0, -1, 0, 1'b1);

    // Reset pulse after beat 1 of a read.
    burst_resp = 1'b0;
    line_read  = 1'b1;
    line_addr  = 32'hCAFE_0120;
    @(posedge clk);
    @(negedge clk);
    d0 = {$urandom, $urandom};
    burst_rdata = d0;
    burst_resp  = 1'b1;
    @(negedge clk);
    d1 = {$urandom, $urandom};
    burst_rdata = d1;
    @(negedge clk);
    burst_resp = 1'b0;
    line_read  = 1'b0;
    rst        = 1'b0;
    #1 check_all_zero("mid_reset");
    last_read = '0;
    @(negedge clk);
    rst = 1'b1;
    txn("rd_after_reset", 1'b1, 1'b0, 32'hBEEF_0080, '0, 1'b0, '0, -1, 0, 1'b1);

    // Back-to-back read / write / read.
    txn("b2b_rd0", 1'b1, 1'b0, $urandom, '0, 1'b0, '0, -1, 0, 1'b0);
    txn("b2b_wr", 1'b0, 1'b1, $urandom, rand256(), 1'b0, '0, -1, 0, 1'b0);
    txn("b2b_rd1", 1'b1, 1'b0, $urandom, '0, 1'b0, '0, -1, 0, 1'b0);

    // Randomized traffic with stalls and idle gaps.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 0)
        txn("rand_rd", 1'b1, 1'b0, $urandom, '0, 1'b0, '0, -1, 0, 1'b1);
      else
        txn("rand_wr", 1'b0, 1'b1, $urandom, rand256(), 1'b0, '0, -1, 0, 1'b1);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge clk);
        check("gap_idle", {line_resp, burst_read, burst_write}, 3'b000);
        check("gap_rdata", line_rdata, last_read);
        burst_resp  = 1'($urandom_range(0, 1));
        burst_rdata = {$urandom, $urandom};
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
